// File: rtl/layer1_result_ctrl.sv
// ---------------------------------------------------------------------------------------------
// layer1_result_ctrl
//
// Sequencer and read scheduler for the layer-1 result SRAM (dual-port: port A write, port B
// read, 1-cycle read latency). Incoming layer-1 words are assigned row/column save addresses
// over a WIDTH x WIDTH map and written one cycle after acceptance. Reads from the layer-2 /
// AXI side are granted only once the addressed entry has been committed, so nothing is ever
// read before it is written. A one-cycle pulse marks completion of the map.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_start          pulse: begin a new map fill (ignored while filling)
//   i_in_valid       layer-1 result word valid
//   i_in_data        layer-1 result word
//   o_in_ready       word accepted when i_in_valid & o_in_ready
//   o_save_enable    SRAM port-A write strobe
//   o_save_row_addr  write row
//   o_save_col_addr  write column
//   o_store_data     SRAM write data
//   i_rd_req         read request, held by the requester until granted
//   i_rd_addr        linear read address, row*WIDTH+col
//   o_rd_gnt         request accepted this cycle (combinational)
//   o_rd_err         request address out of range (combinational)
//   o_read_signal    SRAM port-B enable / output gate
//   o_araddr         SRAM read address
//   o_rd_data_valid  SRAM read data valid this cycle
//   o_busy           map fill in progress
//   o_layer_done     one-cycle pulse after the last write commits
// ---------------------------------------------------------------------------------------------
module layer1_result_ctrl #(
  parameter int unsigned WIDTH  = 30,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_save_enable,
  output logic [15:0]       o_save_row_addr,
  output logic [15:0]       o_save_col_addr,
  output logic [DATA_W-1:0] o_store_data,
  input  logic              i_rd_req,
  input  logic [31:0]       i_rd_addr,
  output logic              o_rd_gnt,
  output logic              o_rd_err,
  output logic              o_read_signal,
  output logic [31:0]       o_araddr,
  output logic              o_rd_data_valid,
  output logic              o_busy,
  output logic              o_layer_done
);

  localparam int unsigned       Total     = WIDTH * WIDTH;
  localparam logic [31:0]       TotalAddr = 32'(Total);
  localparam logic [ADDR_W-1:0] LastCount = ADDR_W'(Total - 1);
  localparam logic [15:0]       LastIdx   = 16'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDone
  } state_e;

  state_e r_state;
  state_e w_state_next;

  // Fill bookkeeping.
  logic [15:0]       r_row;
  logic [15:0]       r_col;
  logic              r_last_acc;   // final map word already accepted
  logic [ADDR_W-1:0] r_wr_count;   // committed writes, 0..Total

  // Registered write port.
  logic              r_save_enable;
  logic [15:0]       r_save_row;
  logic [15:0]       r_save_col;
  logic [DATA_W-1:0] r_store_data;

  logic              r_layer_done;

  // Read side.
  logic              r_rd_data_valid;
  logic [31:0]       r_araddr;

  logic w_clear;
  logic w_accept;
  logic w_last_commit;
  logic w_in_range;
  logic w_written;

  // -------------------------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------------------------
  // The write committing the final map entry is the one in flight when wr_count == Total-1.
  assign w_last_commit = r_save_enable && (r_wr_count == LastCount);

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next = StFill;
          w_clear      = 1'b1;
        end
      end
      StFill: begin
        // start is deliberately ignored here.
        if (w_last_commit) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (i_start) begin
          w_state_next = StFill;
          w_clear      = 1'b1;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Input acceptance and address generation
  // -------------------------------------------------------------------------------------------
  assign o_in_ready = (r_state == StFill) && !r_last_acc;
  assign w_accept   = i_in_valid && o_in_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row      <= '0;
      r_col      <= '0;
      r_last_acc <= 1'b0;
    end else if (w_clear) begin
      r_row      <= '0;
      r_col      <= '0;
      r_last_acc <= 1'b0;
    end else if (w_accept) begin
      if (r_col == LastIdx) begin
        r_col <= '0;
        // Row is left at WIDTH-1 after the final word; in_ready is already down.
        if (r_row == LastIdx) begin
          r_last_acc <= 1'b1;
        end else begin
          r_row <= r_row + 16'd1;
        end
      end else begin
        r_col <= r_col + 16'd1;
      end
    end
  end

  // -------------------------------------------------------------------------------------------
  // Write port: one cycle behind acceptance
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_save_enable <= 1'b0;
      r_save_row    <= '0;
      r_save_col    <= '0;
      r_store_data  <= '0;
    end else begin
      r_save_enable <= w_accept;
      if (w_accept) begin
        r_save_row   <= r_row;
        r_save_col   <= r_col;
        r_store_data <= i_in_data;
      end
    end
  end

  // wr_count only moves once a write has actually been presented to the SRAM, which is what
  // keeps a same-cycle read of the entry being written from being granted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_count <= '0;
    end else if (w_clear) begin
      r_wr_count <= '0;
    end else if (r_save_enable) begin
      r_wr_count <= r_wr_count + ADDR_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_layer_done <= 1'b0;
    end else begin
      r_layer_done <= (r_state == StFill) && w_last_commit;
    end
  end

  assign o_save_enable   = r_save_enable;
  assign o_save_row_addr = r_save_row;
  assign o_save_col_addr = r_save_col;
  assign o_store_data    = r_store_data;
  assign o_busy          = (r_state == StFill);
  assign o_layer_done    = r_layer_done;

  // -------------------------------------------------------------------------------------------
  // Read scheduling
  // -------------------------------------------------------------------------------------------
  assign w_in_range = (i_rd_addr < TotalAddr);
  assign w_written  = (i_rd_addr[ADDR_W-1:0] < r_wr_count);

  assign o_rd_err = i_rd_req && !w_in_range;
  assign o_rd_gnt = i_rd_req && w_in_range && w_written;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data_valid <= 1'b0;
      r_araddr        <= '0;
    end else begin
      r_rd_data_valid <= o_rd_gnt;
      if (o_rd_gnt) begin
        r_araddr <= i_rd_addr;
      end
    end
  end

  // The memory zeroes its output while read_signal is low, so keep it up through the data
  // cycle; araddr likewise holds the granted address unless a new grant replaces it.
  assign o_read_signal   = o_rd_gnt || r_rd_data_valid;
  assign o_araddr        = o_rd_gnt ? i_rd_addr : r_araddr;
  assign o_rd_data_valid = r_rd_data_valid;

  // -------------------------------------------------------------------------------------------
  // Invariants
  // -------------------------------------------------------------------------------------------
  a_gnt_err_excl : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(o_rd_gnt && o_rd_err));

  a_wr_count_range : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (32'(r_wr_count) <= TotalAddr));

  a_no_write_outside_fill : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (r_save_enable |-> (r_state == StFill)));

endmodule

// File: tb/tb_layer1_result_ctrl.sv
module tb_layer1_result_ctrl;

  localparam int W     = 30;
  localparam int TOTAL = W * W;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_ready;
  logic         save_enable;
  logic [15:0]  save_row_addr;
  logic [15:0]  save_col_addr;
  logic [127:0] store_data;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic         rd_gnt;
  logic         rd_err;
  logic         read_signal;
  logic [31:0]  araddr;
  logic         rd_data_valid;
  logic         busy;
  logic         layer_done;

  layer1_result_ctrl #(
    .WIDTH (W),
    .DATA_W(128),
    .ADDR_W(10)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_in_valid     (in_valid),
    .i_in_data      (in_data),
    .o_in_ready     (in_ready),
    .o_save_enable  (save_enable),
    .o_save_row_addr(save_row_addr),
    .o_save_col_addr(save_col_addr),
    .o_store_data   (store_data),
    .i_rd_req       (rd_req),
    .i_rd_addr      (rd_addr),
    .o_rd_gnt       (rd_gnt),
    .o_rd_err       (rd_err),
    .o_read_signal  (read_signal),
    .o_araddr       (araddr),
    .o_rd_data_valid(rd_data_valid),
    .o_busy         (busy),
    .o_layer_done   (layer_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues: pushed by the reference model, popped by the monitor.
  typedef struct {
    logic [15:0]  row;
    logic [15:0]  col;
    logic [127:0] data;
  } wr_t;
  wr_t         wq[$];
  logic [31:0] rq[$];

  // Reference model state. A word accepted in cycle k is written in k+1 and counts as
  // readable from cycle k+2 on, so the readable count is the accept total two cycles back.
  bit m_started;
  int m_acc;
  int m_hist1, m_hist2, m_hist3;
  bit m_prev_gnt, m_prev_acc;
  bit m_last_gnt, m_last_err, m_last_acc;
  int ld_count = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_started  = 0;
      m_acc      = 0;
      m_hist1    = 0;
      m_hist2    = 0;
      m_hist3    = 0;
      m_prev_gnt = 0;
      m_prev_acc = 0;
      m_last_gnt = 0;
      m_last_err = 0;
      m_last_acc = 0;
      wq.delete();
      rq.delete();
    end else begin
      int  committed;
      bit  e_ready, e_busy, e_done, e_gnt, e_err, acc_now;
      wr_t w;
      committed = m_hist2;
      e_ready   = m_started && (m_acc < TOTAL);
      e_busy    = m_started && (committed < TOTAL);
      e_done    = (committed == TOTAL) && (m_hist3 == TOTAL - 1);
      e_err     = rd_req && (rd_addr >= 32'(TOTAL));
      e_gnt     = rd_req && (rd_addr < 32'(TOTAL)) && (rd_addr < 32'(committed));
      check("in_ready", 128'(in_ready), 128'(e_ready));
      check("busy", 128'(busy), 128'(e_busy));
      check("layer_done", 128'(layer_done), 128'(e_done));
      check("rd_err", 128'(rd_err), 128'(e_err));
      check("rd_gnt", 128'(rd_gnt), 128'(e_gnt));
      check("read_signal", 128'(read_signal), 128'(e_gnt || m_prev_gnt));
      check("rd_data_valid", 128'(rd_data_valid), 128'(m_prev_gnt));
      check("save_enable", 128'(save_enable), 128'(m_prev_acc));
      if (e_gnt) begin
        check("araddr_at_grant", 128'(araddr), 128'(rd_addr));
        rq.push_back(rd_addr);
      end
      acc_now = in_valid && e_ready;
      if (acc_now) begin
        w.row  = 16'(m_acc / W);
        w.col  = 16'(m_acc % W);
        w.data = in_data;
        wq.push_back(w);
        m_acc++;
      end
      m_hist3    = m_hist2;
      m_hist2    = m_hist1;
      m_hist1    = m_acc;
      m_prev_gnt = e_gnt;
      m_prev_acc = acc_now;
      m_last_gnt = e_gnt;
      m_last_err = e_err;
      m_last_acc = acc_now;
      if (start && !e_busy) begin
        m_started = 1;
        m_acc     = 0;
        m_hist1   = 0;
        m_hist2   = 0;
        m_hist3   = 0;
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT presents a write or read data.
  wr_t         mon_w;
  logic [31:0] mon_a;
  always @(negedge clk) begin
    if (rst_n) begin
      if (layer_done) ld_count++;
      if (save_enable) begin
        if (wq.size() == 0) begin
          check("unexpected_write", 128'(save_enable), 128'(0));
        end else begin
          mon_w = wq.pop_front();
          check("save_row", 128'(save_row_addr), 128'(mon_w.row));
          check("save_col", 128'(save_col_addr), 128'(mon_w.col));
          check("store_data", store_data, mon_w.data);
        end
      end
      if (rd_data_valid) begin
        if (rq.size() == 0) begin
          check("unexpected_rdata", 128'(rd_data_valid), 128'(0));
        end else begin
          mon_a = rq.pop_front();
          if (!rd_gnt) check("araddr_hold", 128'(araddr), 128'(mon_a));
        end
      end
    end
  end

  // Stimulus.
  bit fill_mode = 0;
  bit b2b       = 0;
  bit rd_rand   = 0;

  task automatic cycle();
    @(posedge clk);
    #1;
    if (fill_mode) begin
      if (!in_valid || m_last_acc) begin
        in_valid = b2b ? 1'b1 : ($urandom_range(0, 3) != 0);
        in_data  = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    if (rd_rand) begin
      if (!rd_req || m_last_gnt || m_last_err) begin
        rd_req  = ($urandom_range(0, 2) != 0);
        rd_addr = 32'($urandom_range(0, 950));
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 128'(in_ready), 128'(0));
    check({tag, "_save_enable"}, 128'(save_enable), 128'(0));
    check({tag, "_save_row"}, 128'(save_row_addr), 128'(0));
    check({tag, "_save_col"}, 128'(save_col_addr), 128'(0));
    check({tag, "_store_data"}, store_data, 128'(0));
    check({tag, "_rd_gnt"}, 128'(rd_gnt), 128'(0));
    check({tag, "_rd_err"}, 128'(rd_err), 128'(0));
    check({tag, "_read_signal"}, 128'(read_signal), 128'(0));
    check({tag, "_araddr"}, 128'(araddr), 128'(0));
    check({tag, "_rd_data_valid"}, 128'(rd_data_valid), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_layer_done"}, 128'(layer_done), 128'(0));
  endtask

  // Runs until the model sees the whole map committed, with a cycle budget.
  task automatic run_fill(input string tag, input bit enable_rand_after_gnt);
    int guard;
    guard = 0;
    while (!(m_started && m_hist2 >= TOTAL) && guard < 6000) begin
      cycle();
      if (enable_rand_after_gnt && !rd_rand && m_last_gnt) rd_rand = 1;
      guard++;
    end
    if (guard >= 6000) check({tag, "_timeout"}, 128'(guard), 128'(0));
  endtask

  initial begin
    int dir;
    int guard;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    rd_req   = 1'b0;
    rd_addr  = '0;
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reads in IDLE before any fill must stall.
    rd_req  = 1'b1;
    rd_addr = 32'd0;
    repeat (3) cycle();
    rd_req = 1'b0;
    cycle();

    // Fill 1: back-to-back words with directed reads.
    pulse_start();
    fill_mode = 1;
    b2b       = 1;
    dir       = 0;
    guard     = 0;
    while (!(m_hist2 >= TOTAL) && guard < 3000) begin
      cycle();
      guard++;
      case (dir)
        0: if (m_acc >= 36) begin rd_req = 1'b1; rd_addr = 32'd40; dir = 1; end
        1: if (m_last_gnt) begin rd_req = 1'b0; dir = 2; end
        // Read of the entry being written this very cycle.
        2: if (m_acc >= 100) begin rd_req = 1'b1; rd_addr = 32'(m_acc - 1); dir = 3; end
        3: if (m_last_gnt) begin rd_req = 1'b0; dir = 4; end
        default: ;
      endcase
    end
    if (guard >= 3000) check("fill1_timeout", 128'(guard), 128'(0));
    fill_mode = 0;
    in_valid  = 1'b0;
    rd_req    = 1'b0;
    repeat (3) cycle();
    check("fill1_done_pulses", 128'(ld_count), 128'(1));
    check("fill1_busy_after", 128'(busy), 128'(0));

    // DONE: range boundary and consecutive reads.
    rd_req  = 1'b1;
    rd_addr = 32'd900;
    cycle();
    rd_addr = 32'd899;
    cycle();
    rd_req = 1'b0;
    cycle();
    for (int a = 0; a < 4; a++) begin
      rd_req  = 1'b1;
      rd_addr = 32'(a);
      cycle();
    end
    rd_req = 1'b0;
    repeat (3) cycle();

    // Restart: old contents must become unreadable; random traffic, reset mid-fill.
    rd_req  = 1'b1;
    rd_addr = 32'd5;
    pulse_start();
    fill_mode = 1;
    b2b       = 0;
    guard     = 0;
    while (m_acc < 500 && guard < 3000) begin
      cycle();
      if (!rd_rand && m_last_gnt) rd_rand = 1;
      guard++;
    end
    if (guard >= 3000) check("fill2_timeout", 128'(guard), 128'(0));
    fill_mode = 0;
    rd_rand   = 0;
    in_valid  = 1'b0;
    rd_req    = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    // Post-reset: read of address 0 stalls until the first write commits.
    rd_req  = 1'b1;
    rd_addr = 32'd0;
    cycle();
    pulse_start();
    fill_mode = 1;
    run_fill("fill3", 1'b1);
    fill_mode = 0;
    in_valid  = 1'b0;
    rd_rand   = 0;
    rd_req    = 1'b0;
    repeat (4) cycle();
    check("total_done_pulses", 128'(ld_count), 128'(2));
    check("write_queue_empty", 128'(wq.size()), 128'(0));
    check("read_queue_empty", 128'(rq.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/layer1_result_ctrl.md
Name: layer1_result_ctrl

Overview:
- Sequencer and read scheduler for the layer-1 result SRAM (1024 x 128b dual-port; port A write, port B read, 1-cycle read latency).
- Turns the layer-1 output stream into row/column save addresses over a WIDTH x WIDTH map.
- Gates layer-2/AXI read requests so that no entry is read before it is written; reports map completion.
- Sits between the layer-1 PE output, the result memory and the layer-2 fetch/AXI read logic.

Parameters:
- WIDTH, 30, map side length; valid linear addresses 0..WIDTH*WIDTH-1.
- DATA_W, 128, result word width.
- ADDR_W, 10, SRAM address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  pulse: begin a new map fill.
- in_valid  in  1  layer-1 result word valid.
- in_data  in  DATA_W  layer-1 result word.
- in_ready  out  1  controller accepts in_data.
- save_enable  out  1  SRAM port-A write strobe, active high.
- save_row_addr  out  16  write row.
- save_col_addr  out  16  write column.
- store_data  out  DATA_W  SRAM write data.
- rd_req  in  1  read request; held until granted.
- rd_addr  in  32  linear read address, row*WIDTH+col.
- rd_gnt  out  1  request accepted this cycle.
- rd_err  out  1  request address out of range.
- read_signal  out  1  SRAM port-B enable / output gate.
- araddr  out  32  SRAM read address.
- rd_data_valid  out  1  SRAM read data valid this cycle.
- busy  out  1  FILL state.
- layer_done  out  1  one-cycle pulse after the last write.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; internal row, col and wr_count = 0.
- States:
  - IDLE -start-> FILL.
  - FILL -last write committed-> DONE.
  - DONE -start-> FILL.
  - start in FILL is ignored.
- Entering FILL clears row, col and wr_count.
- in_ready = 1 only in FILL while the final word has not yet been accepted.
- Write path:
  - Accept on in_valid & in_ready.
  - Next cycle, registered: save_enable=1, save_row_addr=row, save_col_addr=col, store_data=in_data.
  - Write latency is 1 cycle.
  - Back-to-back accepts give one write per cycle.
- Address advance, on each accept:
  - col increments.
  - When col=WIDTH-1: col=0 and row increments.
  - Accepting (WIDTH-1, WIDTH-1) drops in_ready.
- wr_count:
  - Increments on every clock edge where save_enable=1, i.e. it counts committed writes.
  - 10-bit value with range 0..WIDTH*WIDTH.
- After the edge that commits write WIDTH*WIDTH: state DONE, layer_done=1 for exactly one cycle, busy=0.
- Read scheduling, evaluated every cycle with rd_req=1:
  - If rd_addr >= WIDTH*WIDTH: rd_err=1 and rd_gnt=0 in the same cycle (combinational). The requester must drop the request.
  - Else if rd_addr[ADDR_W-1:0] < wr_count: rd_gnt=1 combinationally, read_signal=1, araddr=rd_addr.
  - Else: stall, rd_gnt=0, and the request is held.
- A read to the address being written in the same cycle is never granted, since wr_count has not yet counted that write. This avoids a port collision.
- rd_data_valid is registered: 1 the cycle after a grant.
- read_signal = rd_gnt | rd_data_valid. It is held through the data cycle because the memory zeroes its output while read_signal=0.
- During the data cycle, araddr holds the granted address unless a new grant occurs. Back-to-back grants are allowed, giving one read per cycle.
- In DONE every in-range address is grantable.
- A restart (start in DONE) clears wr_count, so old data becomes unreadable until rewritten.
- Simultaneous write and read: independent ports, both proceed in the same cycle.
- Reset mid-FILL: everything returns to IDLE. A pending rd_data_valid is cleared. The SRAM contents are undefined to the controller.

Test Plan:
- Reset, start, then 900 back-to-back in_valid words:
  - save_row/col sequence (0,0),(0,1)..(0,29),(1,0)..(29,29).
  - in_ready falls after the 900th accept.
  - layer_done pulses once, 2 cycles after the last accept.
  - busy=0 afterwards.
- During fill with wr_count=35, rd_req rd_addr=40: rd_gnt=0 until 6 more writes commit. The grant comes the cycle after wr_count reaches 41. rd_data_valid and read_signal are high the next cycle with araddr=40.
- rd_addr equal to the address being written this cycle (save_enable=1): no grant that cycle; grant the following cycle.
- In DONE, rd_req with rd_addr=900: rd_err=1, rd_gnt=0. With rd_addr=899: granted immediately.
- In DONE, 4 consecutive reads at addresses 0,1,2,3: rd_gnt high for 4 cycles, rd_data_valid high for 4 cycles lagging by 1, read_signal high for 5 cycles.
- Assert rst=0 at write 500 mid-fill: all outputs 0 asynchronously. After release, state IDLE. start then restarts at (0,0), and rd_req addr=0 stalls until the first write commits.
